// File: rtl/cnt_mod_updown_pkg.sv
// -----------------------------------------------------------------------------
// cnt_pkg -- shared definitions for the modulus up/down event counter.
//   SAT_WRAP / SAT_HOLD     : boundary behaviour selector (SAT_MODE parameter)
//   EDGE_LEVEL / EDGE_RISE  : event qualification selector (EDGE_MODE parameter)
//   cnt_op_e                : per-cycle operation chosen by the priority encoder
//   clamp_to_mod()          : limits a value to the range 0..modulus-1
// -----------------------------------------------------------------------------
package cnt_pkg;

    localparam int SAT_WRAP   = 0;
    localparam int SAT_HOLD   = 1;
    localparam int EDGE_LEVEL = 0;
    localparam int EDGE_RISE  = 1;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_STEP,
        OP_LOAD,
        OP_CLEAR
    } cnt_op_e;

    function automatic int unsigned clamp_to_mod(input int unsigned value,
                                                 input int unsigned modulus);
        return (value < modulus) ? value : modulus - 1;
    endfunction

endpackage

// File: rtl/cnt_mod_updown_edge_det.sv
// -----------------------------------------------------------------------------
// edge_det -- event qualifier with a one-bit history register.
//   CLK        in  clock
//   RST        in  asynchronous active-high reset (clears the history)
//   d          in  raw event level
//   level_mode in  1 = pass d through, 0 = report only rising edges of d
//   q          out qualified event (combinational)
// The history register samples d every cycle regardless of level_mode, so a
// caller may switch modes without a stale history.
// -----------------------------------------------------------------------------
module edge_det (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    input  logic level_mode,
    output logic q
);

    logic prev_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= d;
        end
    end

    assign q = level_mode ? d : (d & ~prev_q);

endmodule

// File: rtl/cnt_mod_updown.sv
// -----------------------------------------------------------------------------
// cnt_mod_updown -- parametrised modulus up/down event counter.
// Parameters: WIDTH (count width), MOD (count range 0..MOD-1),
//             SAT_MODE (SAT_WRAP/SAT_HOLD), EDGE_MODE (EDGE_LEVEL/EDGE_RISE)
//   CLK      in  clock, all state updates on rising edge
//   RST      in  asynchronous active-high reset
//   sig_in   in  event input (already synchronous to CLK)
//   dir      in  1 = count up, 0 = count down
//   clear    in  synchronous clear to 0 (highest priority)
//   load     in  synchronous load of load_val (clamped to MOD-1)
//   load_val in  load value
//   ovf_clr  in  clears the sticky ovf flag
//   count    out registered count
//   tc       out registered one-cycle pulse for each boundary step
//   ovf      out sticky boundary flag
// -----------------------------------------------------------------------------
module cnt_mod_updown
    import cnt_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MOD       = 16,
    parameter int SAT_MODE  = SAT_WRAP,
    parameter int EDGE_MODE = EDGE_LEVEL
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             sig_in,
    input  logic             dir,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    if (MOD < 2 || MOD > 2**WIDTH) begin : g_bad_mod
        $error("cnt_mod_updown: MOD=%0d outside 2..2**WIDTH (WIDTH=%0d)", MOD, WIDTH);
    end
    if (SAT_MODE != SAT_WRAP && SAT_MODE != SAT_HOLD) begin : g_bad_sat
        $error("cnt_mod_updown: SAT_MODE=%0d is not 0 or 1", SAT_MODE);
    end
    if (EDGE_MODE != EDGE_LEVEL && EDGE_MODE != EDGE_RISE) begin : g_bad_edge
        $error("cnt_mod_updown: EDGE_MODE=%0d is not 0 or 1", EDGE_MODE);
    end

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MOD - 1);
    localparam logic             LEVEL = (EDGE_MODE == EDGE_LEVEL);
    localparam logic             HOLD  = (SAT_MODE == SAT_HOLD);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] load_clamped;
    logic             step;
    logic             boundary;
    cnt_op_e          op;

    edge_det u_edge_det (
        .CLK        (CLK),
        .RST        (RST),
        .d          (sig_in),
        .level_mode (LEVEL),
        .q          (step)
    );

    assign load_clamped = WIDTH'(clamp_to_mod(32'(load_val), MOD));

    always_comb begin
        if (clear) begin
            op = OP_CLEAR;
        end else if (load) begin
            op = OP_LOAD;
        end else if (step) begin
            op = OP_STEP;
        end else begin
            op = OP_HOLD;
        end
    end

    // Boundaries are compared against MOD-1 / 0 rather than relying on the
    // natural 2**WIDTH rollover, so any legal MOD wraps correctly.
    always_comb begin
        count_d  = count_q;
        boundary = 1'b0;
        case (op)
            OP_CLEAR: count_d = '0;
            OP_LOAD:  count_d = load_clamped;
            OP_STEP: begin
                if (dir) begin
                    if (count_q == TOP) begin
                        boundary = 1'b1;
                        count_d  = HOLD ? TOP : '0;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end else begin
                    if (count_q == '0) begin
                        boundary = 1'b1;
                        count_d  = HOLD ? '0 : TOP;
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
            end
            default: count_d = count_q;
        endcase
        tc_d  = boundary;
        // A boundary step in the same cycle as ovf_clr keeps the flag set.
        ovf_d = boundary | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_cnt_mod_updown.sv
module tb_cnt_mod_updown;

    localparam int N = 5;
    // Instance set: 0 wrap/level MOD10, 1 saturate MOD10, 2 edge MOD10,
    //               3 full-range MOD16, 4 WIDTH8 MOD200.
    localparam int P_W    [N] = '{4, 4, 4, 4, 8};
    localparam int P_MOD  [N] = '{10, 10, 10, 16, 200};
    localparam int P_SAT  [N] = '{0, 1, 0, 0, 0};
    localparam int P_EDGE [N] = '{0, 0, 1, 0, 0};

    logic       CLK = 1'b0;
    logic       RST;
    logic       sig_in, dir, clear, load, ovf_clr;
    logic [7:0] load_val;
    logic [3:0] c4 [4];
    logic [7:0] c8;
    logic       tc_o  [N];
    logic       ovf_o [N];

    int vectors    = 0;
    int miscompares = 0;

    int m_cnt [N];
    int m_prev[N];
    int m_tc  [N];
    int m_ovf [N];

    always #5 CLK = ~CLK;

    cnt_mod_updown #(.WIDTH(4), .MOD(10), .SAT_MODE(0), .EDGE_MODE(0)) u_wrap (
        .CLK(CLK), .RST(RST), .sig_in(sig_in), .dir(dir), .clear(clear), .load(load),
        .load_val(load_val[3:0]), .ovf_clr(ovf_clr), .count(c4[0]), .tc(tc_o[0]), .ovf(ovf_o[0]));
    cnt_mod_updown #(.WIDTH(4), .MOD(10), .SAT_MODE(1), .EDGE_MODE(0)) u_sat (
        .CLK(CLK), .RST(RST), .sig_in(sig_in), .dir(dir), .clear(clear), .load(load),
        .load_val(load_val[3:0]), .ovf_clr(ovf_clr), .count(c4[1]), .tc(tc_o[1]), .ovf(ovf_o[1]));
    cnt_mod_updown #(.WIDTH(4), .MOD(10), .SAT_MODE(0), .EDGE_MODE(1)) u_edge (
        .CLK(CLK), .RST(RST), .sig_in(sig_in), .dir(dir), .clear(clear), .load(load),
        .load_val(load_val[3:0]), .ovf_clr(ovf_clr), .count(c4[2]), .tc(tc_o[2]), .ovf(ovf_o[2]));
    cnt_mod_updown #(.WIDTH(4), .MOD(16), .SAT_MODE(0), .EDGE_MODE(0)) u_full (
        .CLK(CLK), .RST(RST), .sig_in(sig_in), .dir(dir), .clear(clear), .load(load),
        .load_val(load_val[3:0]), .ovf_clr(ovf_clr), .count(c4[3]), .tc(tc_o[3]), .ovf(ovf_o[3]));
    cnt_mod_updown #(.WIDTH(8), .MOD(200), .SAT_MODE(0), .EDGE_MODE(0)) u_w8 (
        .CLK(CLK), .RST(RST), .sig_in(sig_in), .dir(dir), .clear(clear), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr), .count(c8), .tc(tc_o[4]), .ovf(ovf_o[4]));

    // Behavioural reference: plain integer arithmetic on the counter rules.
    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0; m_prev[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
        end
    endfunction

    function automatic void model_edge();
        for (int i = 0; i < N; i++) begin
            int lv;
            int nxt;
            bit stp;
            bit bnd;
            lv  = int'(load_val) % (1 << P_W[i]);
            stp = (P_EDGE[i] == 1) ? (sig_in && (m_prev[i] == 0)) : sig_in;
            m_prev[i] = sig_in ? 1 : 0;
            bnd = 1'b0;
            if (clear) begin
                m_cnt[i] = 0;
            end else if (load) begin
                m_cnt[i] = (lv < P_MOD[i]) ? lv : P_MOD[i] - 1;
            end else if (stp) begin
                nxt = m_cnt[i] + (dir ? 1 : -1);
                if (nxt < 0 || nxt >= P_MOD[i]) begin
                    bnd = 1'b1;
                    if (P_SAT[i] == 0) m_cnt[i] = (nxt + P_MOD[i]) % P_MOD[i];
                end else begin
                    m_cnt[i] = nxt;
                end
            end
            m_tc[i] = bnd ? 1 : 0;
            if (bnd) m_ovf[i] = 1;
            else if (ovf_clr) m_ovf[i] = 0;
        end
    endfunction

    function automatic logic [31:0] obs_cnt(int i);
        if (i == 4) return 32'(c8);
        return 32'(c4[i]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s.d%0d.count", tag, i), obs_cnt(i), 32'(m_cnt[i]));
            chk($sformatf("%s.d%0d.tc", tag, i), 32'(tc_o[i]), 32'(m_tc[i]));
            chk($sformatf("%s.d%0d.ovf", tag, i), 32'(ovf_o[i]), 32'(m_ovf[i]));
        end
    endtask

    task automatic drive(input bit s, input bit d, input bit c, input bit l,
                         input int lv, input bit oc);
        sig_in = s; dir = d; clear = c; load = l; load_val = 8'(lv); ovf_clr = oc;
    endtask

    task automatic cyc(input string tag);
        @(posedge CLK);
        model_edge();
        #1;
        check_model(tag);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset(input string tag);
        #2 RST = 1'b1;
        #1;
        model_reset();
        check_model(tag);
        #1 RST = 1'b0;
    endtask

    initial begin
        int sig_pat [8];
        int edge_exp[8];
        sig_pat  = '{1, 1, 1, 1, 1, 0, 0, 1};
        edge_exp = '{1, 1, 1, 1, 1, 1, 1, 2};

        RST = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #12;
        model_reset();
        check_model("reset");
        RST = 1'b0;

        // Reset mid-count
        drive(1, 1, 0, 0, 0, 0);
        for (int k = 0; k < 7; k++) cyc("t1");
        chk("t1.count7", 32'(c4[0]), 32'd7);
        async_reset("t1.rst");
        chk("t1.rst.count", 32'(c4[0]), 32'd0);
        chk("t1.rst.ovf", 32'(ovf_o[0]), 32'd0);

        // Wrap up: 1..9,0,1,2 with tc only on the 0
        for (int k = 0; k < 12; k++) begin
            cyc("t2");
            chk($sformatf("t2.count[%0d]", k), 32'(c4[0]), 32'((k + 1) % 10));
            chk($sformatf("t2.tc[%0d]", k), 32'(tc_o[0]), (k == 9) ? 32'd1 : 32'd0);
        end
        chk("t2.ovf", 32'(ovf_o[0]), 32'd1);

        // Saturate down from 2
        drive(0, 0, 0, 1, 2, 1);
        cyc("t3.load");
        chk("t3.load.count", 32'(c4[1]), 32'd2);
        chk("t3.load.ovf", 32'(ovf_o[1]), 32'd0);
        drive(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            cyc("t3");
            chk($sformatf("t3.count[%0d]", k), 32'(c4[1]), (k == 0) ? 32'd1 : 32'd0);
            chk($sformatf("t3.tc[%0d]", k), 32'(tc_o[1]), (k >= 2) ? 32'd1 : 32'd0);
        end
        chk("t3.ovf", 32'(ovf_o[1]), 32'd1);
        drive(1, 0, 0, 0, 0, 1);
        cyc("t3.setwins");
        chk("t3.setwins.ovf", 32'(ovf_o[1]), 32'd1);
        chk("t3.setwins.tc", 32'(tc_o[1]), 32'd1);
        drive(0, 0, 0, 0, 0, 1);
        cyc("t3.ovfclr");
        chk("t3.ovfclr.ovf", 32'(ovf_o[1]), 32'd0);

        // Edge mode: high 5, low 2, high 1
        drive(0, 1, 1, 0, 0, 0);
        cyc("t4.clear");
        for (int k = 0; k < 8; k++) begin
            drive(sig_pat[k] != 0, 1, 0, 0, 0, 0);
            cyc("t4");
            chk($sformatf("t4.count[%0d]", k), 32'(c4[2]), 32'(edge_exp[k]));
        end

        // Priority and clamp
        drive(0, 1, 0, 1, 13, 0);
        cyc("t5.clamp");
        chk("t5.clamp.count", 32'(c4[0]), 32'd9);
        drive(1, 1, 1, 1, 5, 0);
        cyc("t5.clrwins");
        chk("t5.clrwins.count", 32'(c4[0]), 32'd0);
        chk("t5.clrwins.tc", 32'(tc_o[0]), 32'd0);
        drive(0, 1, 0, 1, 9, 0);
        cyc("t5.load9");
        drive(1, 1, 0, 1, 4, 0);
        cyc("t5.loadwins");
        chk("t5.loadwins.count", 32'(c4[0]), 32'd4);
        chk("t5.loadwins.tc", 32'(tc_o[0]), 32'd0);

        // Full range
        drive(0, 0, 1, 0, 0, 0);
        cyc("t6.clear");
        drive(1, 0, 0, 0, 0, 0);
        cyc("t6.down");
        chk("t6.m16.count", 32'(c4[3]), 32'd15);
        chk("t6.m16.tc", 32'(tc_o[3]), 32'd1);
        drive(0, 1, 0, 1, 199, 0);
        cyc("t6.load199");
        chk("t6.m200.load", 32'(c8), 32'd199);
        drive(1, 1, 0, 0, 0, 0);
        cyc("t6.up");
        chk("t6.m200.count", 32'(c8), 32'd0);
        chk("t6.m200.tc", 32'(tc_o[4]), 32'd1);

        // Randomised traffic against the reference model
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0,
                  int'($urandom_range(0, 255)), $urandom_range(0, 7) == 0);
            cyc("rand");
            if ($urandom_range(0, 49) == 0) async_reset("rand.rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
